// File: rtl/rvcpu_mem_pkg.sv
// Shared load/store encodings, FSM state codes and access-size helpers for the MEM stage.
package rvcpu_mem_pkg;

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LBU  = 3'd2;
    localparam logic [2:0] LD_LH   = 3'd3;
    localparam logic [2:0] LD_LHU  = 3'd4;
    localparam logic [2:0] LD_LW   = 3'd5;
    localparam logic [2:0] LD_LWU  = 3'd6;
    localparam logic [2:0] LD_LD   = 3'd7;

    localparam logic [2:0] ST_NONE = 3'd0;
    localparam logic [2:0] ST_SB   = 3'd1;
    localparam logic [2:0] ST_SH   = 3'd2;
    localparam logic [2:0] ST_SW   = 3'd3;
    localparam logic [2:0] ST_SD   = 3'd4;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Offset bits that remain meaningful for a naturally aligned access of this size.
    function automatic logic [2:0] align_mask(input logic [1:0] sz);
        case (sz)
            SZ_B:    align_mask = 3'b111;
            SZ_H:    align_mask = 3'b110;
            SZ_W:    align_mask = 3'b100;
            default: align_mask = 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] load_size(input logic [2:0] ctrl);
        case (ctrl)
            LD_LB, LD_LBU: load_size = SZ_B;
            LD_LH, LD_LHU: load_size = SZ_H;
            LD_LW, LD_LWU: load_size = SZ_W;
            default:       load_size = SZ_D;
        endcase
    endfunction

    function automatic logic [1:0] store_size(input logic [2:0] ctrl);
        case (ctrl)
            ST_SB:   store_size = SZ_B;
            ST_SH:   store_size = SZ_H;
            ST_SW:   store_size = SZ_W;
            default: store_size = SZ_D;
        endcase
    endfunction

    function automatic logic [7:0] be_base(input logic [1:0] sz);
        case (sz)
            SZ_B:    be_base = 8'h01;
            SZ_H:    be_base = 8'h03;
            SZ_W:    be_base = 8'h0F;
            default: be_base = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: shift the addressed lane down, truncate to access size, sign/zero extend.
module mem_load_align
    import rvcpu_mem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      off,
    input  logic [2:0]      dm_rd_ctrl,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] sh;

    assign sh = rdata >> {off, 3'b000};

    always_comb begin
        data = '0;
        case (dm_rd_ctrl)
            LD_LB:   data = {{(XLEN-8){sh[7]}}, sh[7:0]};
            LD_LBU:  data = {{(XLEN-8){1'b0}}, sh[7:0]};
            LD_LH:   data = {{(XLEN-16){sh[15]}}, sh[15:0]};
            LD_LHU:  data = {{(XLEN-16){1'b0}}, sh[15:0]};
            LD_LW:   data = {{(XLEN-32){sh[31]}}, sh[31:0]};
            LD_LWU:  data = {{(XLEN-32){1'b0}}, sh[31:0]};
            LD_LD:   data = sh;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/pipeline_mem_stage.sv
// RV64 MEM stage: dmem request/ready handshake, load alignment, upstream stall, MEM/WB register.
// Optional misaligned-access trap flag enabled by defining MEM_MISALIGN_CHECK_EN.
module pipeline_mem_stage
    import rvcpu_mem_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int BE_W = XLEN / 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_out,
    input  logic [XLEN-1:0] alu_result_EX,
    input  logic [XLEN-1:0] reg_data2_MEM,
    input  logic [4:0]      rd_MEM,
    input  logic            rf_wr_en_EX,
    input  logic [1:0]      rf_wr_sel_EX,
    input  logic [2:0]      dm_rd_ctrl_EX,
    input  logic [2:0]      dm_wr_ctrl_EX,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [BE_W-1:0] dmem_be,
    output logic            stall_MEM,
    output logic [XLEN-1:0] pc_WB,
    output logic [XLEN-1:0] alu_result_WB,
    output logic [XLEN-1:0] mem_rdata_WB,
    output logic [4:0]      rd_WB,
    output logic            rf_wr_en_WB,
    output logic [1:0]      rf_wr_sel_WB,
    output logic            misalign_MEM
);

    logic            is_store;
    logic            is_load;
    logic            mem_raw;
    logic            misalign;
    logic            mem_op;
    logic [1:0]      sz;
    logic [2:0]      off;
    logic [2:0]      eff_off;
    logic [XLEN-1:0] ld_data;
    logic [0:0]      state;
    logic [0:0]      state_nxt;

    // Store codes 5-7 are not stores; a valid store overrides any simultaneous load.
    assign is_store = (dm_wr_ctrl_EX >= ST_SB) && (dm_wr_ctrl_EX <= ST_SD);
    assign is_load  = (dm_rd_ctrl_EX != LD_NONE) && !is_store;
    assign mem_raw  = is_store || is_load;
    assign sz       = is_store ? store_size(dm_wr_ctrl_EX) : load_size(dm_rd_ctrl_EX);
    assign off      = alu_result_EX[2:0];

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign = mem_raw && ((off & ~align_mask(sz)) != 3'b000);
    assign eff_off  = off;
`else
    // Without the check, low offset bits below natural alignment are silently dropped.
    assign misalign = 1'b0;
    assign eff_off  = off & align_mask(sz);
`endif

    assign mem_op    = mem_raw && !misalign;
    assign dmem_req  = mem_op;
    assign dmem_we   = is_store && mem_op;
    assign stall_MEM = mem_op && !dmem_ready;
    assign dmem_addr = {alu_result_EX[XLEN-1:3], 3'b000};
    assign dmem_be   = dmem_we ? BE_W'(be_base(sz) << eff_off) : '0;

    always_comb begin
        dmem_wdata = '0;
        case (dm_wr_ctrl_EX)
            ST_SB:   dmem_wdata = {(XLEN/8){reg_data2_MEM[7:0]}};
            ST_SH:   dmem_wdata = {(XLEN/16){reg_data2_MEM[15:0]}};
            ST_SW:   dmem_wdata = {(XLEN/32){reg_data2_MEM[31:0]}};
            ST_SD:   dmem_wdata = reg_data2_MEM;
            default: dmem_wdata = '0;
        endcase
    end

    mem_load_align #(.XLEN(XLEN)) u_align (
        .rdata      (dmem_rdata),
        .off        (eff_off),
        .dm_rd_ctrl (dm_rd_ctrl_EX),
        .data       (ld_data)
    );

    // The handshake outputs are purely combinational; the state only tracks an outstanding request.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (mem_op && !dmem_ready) state_nxt = S_WAIT;
            default: if (dmem_ready) state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            pc_WB         <= '0;
            alu_result_WB <= '0;
            mem_rdata_WB  <= '0;
            rd_WB         <= '0;
            rf_wr_en_WB   <= 1'b0;
            rf_wr_sel_WB  <= '0;
            misalign_MEM  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (stall_MEM) begin
                rd_WB        <= '0;
                rf_wr_en_WB  <= 1'b0;
                misalign_MEM <= 1'b0;
            end else begin
                pc_WB         <= pc_out;
                alu_result_WB <= alu_result_EX;
                mem_rdata_WB  <= (is_load && !misalign) ? ld_data : '0;
                rd_WB         <= rd_MEM;
                rf_wr_en_WB   <= rf_wr_en_EX && !misalign;
                rf_wr_sel_WB  <= rf_wr_sel_EX;
                misalign_MEM  <= misalign;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Directed bench for pipeline_mem_stage: vector table plus stall and reset-in-wait sequences.
module tb_pipeline_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc_out, alu_result_EX, reg_data2_MEM, dmem_rdata;
    logic [4:0]  rd_MEM;
    logic        rf_wr_en_EX, dmem_ready;
    logic [1:0]  rf_wr_sel_EX;
    logic [2:0]  dm_rd_ctrl_EX, dm_wr_ctrl_EX;
    logic        dmem_req, dmem_we, stall_MEM, rf_wr_en_WB, misalign_MEM;
    logic [63:0] dmem_addr, dmem_wdata, pc_WB, alu_result_WB, mem_rdata_WB;
    logic [7:0]  dmem_be;
    logic [4:0]  rd_WB;
    logic [1:0]  rf_wr_sel_WB;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pipeline_mem_stage dut (
        .clk(clk), .reset(reset), .pc_out(pc_out), .alu_result_EX(alu_result_EX),
        .reg_data2_MEM(reg_data2_MEM), .rd_MEM(rd_MEM), .rf_wr_en_EX(rf_wr_en_EX),
        .rf_wr_sel_EX(rf_wr_sel_EX), .dm_rd_ctrl_EX(dm_rd_ctrl_EX), .dm_wr_ctrl_EX(dm_wr_ctrl_EX),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .stall_MEM(stall_MEM),
        .pc_WB(pc_WB), .alu_result_WB(alu_result_WB), .mem_rdata_WB(mem_rdata_WB), .rd_WB(rd_WB),
        .rf_wr_en_WB(rf_wr_en_WB), .rf_wr_sel_WB(rf_wr_sel_WB), .misalign_MEM(misalign_MEM)
    );

    typedef struct {
        logic [63:0] alu, d2, rdata;
        logic [4:0]  rd;
        logic        wen;
        logic [1:0]  sel;
        logic [2:0]  rdc, wrc;
        logic        e_req, e_we, e_wen, e_mis;
        logic [63:0] e_addr, e_wdata, e_mrd;
        logic [7:0]  e_be;
    } vec_t;

    vec_t vq[$];

    localparam logic [63:0] R1 = 64'h1122_F044_5566_7788;
    localparam logic [63:0] R2 = 64'h1234_8001_5678_9ABC;
    localparam logic [63:0] R3 = 64'h0000_0000_8765_4321;

    task automatic add(input logic [63:0] alu, input logic [63:0] d2, input logic [4:0] rd,
                       input logic wen, input logic [1:0] sel, input logic [2:0] rdc,
                       input logic [2:0] wrc, input logic [63:0] rdata,
                       input logic e_req, input logic e_we, input logic [63:0] e_addr,
                       input logic [63:0] e_wdata, input logic [7:0] e_be,
                       input logic [63:0] e_mrd, input logic e_wen, input logic e_mis);
        vec_t v;
        v.alu = alu; v.d2 = d2; v.rd = rd; v.wen = wen; v.sel = sel; v.rdc = rdc; v.wrc = wrc;
        v.rdata = rdata; v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.e_be = e_be; v.e_mrd = e_mrd; v.e_wen = e_wen; v.e_mis = e_mis;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic [63:0] pc, input logic [63:0] alu, input logic [63:0] d2,
                         input logic [4:0] rd, input logic wen, input logic [1:0] sel,
                         input logic [2:0] rdc, input logic [2:0] wrc, input logic rdy,
                         input logic [63:0] rdata);
        pc_out = pc; alu_result_EX = alu; reg_data2_MEM = d2; rd_MEM = rd; rf_wr_en_EX = wen;
        rf_wr_sel_EX = sel; dm_rd_ctrl_EX = rdc; dm_wr_ctrl_EX = wrc; dmem_ready = rdy;
        dmem_rdata = rdata;
    endtask

    task automatic chk_wb_zero(input string tag);
        chk({tag, ".pc_WB"}, pc_WB, 64'h0);
        chk({tag, ".alu_WB"}, alu_result_WB, 64'h0);
        chk({tag, ".mrd_WB"}, mem_rdata_WB, 64'h0);
        chk({tag, ".rd_WB"}, 64'(rd_WB), 64'h0);
        chk({tag, ".wen_WB"}, 64'(rf_wr_en_WB), 64'h0);
        chk({tag, ".sel_WB"}, 64'(rf_wr_sel_WB), 64'h0);
        chk({tag, ".mis"}, 64'(misalign_MEM), 64'h0);
    endtask

    initial begin
        // alu, d2, rd, wen, sel, rdc, wrc, rdata | req, we, addr, wdata, be, mrd, wen_WB, mis
        add(64'h1234, 64'h0, 5, 1, 0, 0, 0, 64'h0, 0, 0, 64'h1230, 64'h0, 8'h00, 64'h0, 1, 0);
        add(64'h1003, 64'h1122334455667_7AB, 0, 0, 0, 0, 1, 64'h0,
            1, 1, 64'h1000, 64'hABAB_ABAB_ABAB_ABAB, 8'h08, 64'h0, 0, 0);
        add(64'h2005, 64'h0, 7, 1, 1, 1, 0, R1, 1, 0, 64'h2000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFF0, 1, 0);
        add(64'h2005, 64'h0, 7, 1, 1, 2, 0, R1, 1, 0, 64'h2000, 64'h0, 8'h00, 64'h0000_0000_0000_00F0, 1, 0);
        add(64'h2004, 64'h0, 8, 1, 1, 3, 0, R2, 1, 0, 64'h2000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_8001, 1, 0);
        add(64'h2000, 64'h0, 8, 1, 1, 4, 0, R2, 1, 0, 64'h2000, 64'h0, 8'h00, 64'h0000_0000_0000_9ABC, 1, 0);
        add(64'h2000, 64'h0, 9, 1, 1, 5, 0, R2, 1, 0, 64'h2000, 64'h0, 8'h00, 64'h0000_0000_5678_9ABC, 1, 0);
        add(64'h2004, 64'h0, 9, 1, 1, 6, 0, R2, 1, 0, 64'h2000, 64'h0, 8'h00, 64'h0000_0000_1234_8001, 1, 0);
        add(64'h2008, 64'h0, 10, 1, 1, 7, 0, R2, 1, 0, 64'h2008, 64'h0, 8'h00, R2, 1, 0);
        add(64'h100A, 64'h0000_0000_0000_BEEF, 0, 0, 0, 0, 2, 64'h0,
            1, 1, 64'h1008, 64'hBEEF_BEEF_BEEF_BEEF, 8'h0C, 64'h0, 0, 0);
        add(64'h1014, 64'hCAFE_F00D_DEAD_BEEF, 0, 0, 0, 0, 3, 64'h0,
            1, 1, 64'h1010, 64'hDEAD_BEEF_DEAD_BEEF, 8'hF0, 64'h0, 0, 0);
        add(64'h1018, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 4, 64'h0,
            1, 1, 64'h1018, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 0, 0);
        add(64'h1001, 64'h5A, 4, 1, 2, 7, 1, R2, 1, 1, 64'h1000, 64'h5A5A_5A5A_5A5A_5A5A, 8'h02, 64'h0, 1, 0);
        add(64'h77, 64'hFF, 9, 1, 0, 0, 5, 64'h0, 0, 0, 64'h70, 64'h0, 8'h00, 64'h0, 1, 0);
        add(64'h2005, 64'h0, 8, 1, 1, 2, 6, R1, 1, 0, 64'h2000, 64'h0, 8'h00, 64'hF0, 1, 0);
`ifdef MEM_MISALIGN_CHECK_EN
        add(64'h4004, 64'h0, 11, 1, 1, 7, 0, R2, 0, 0, 64'h4000, 64'h0, 8'h00, 64'h0, 0, 1);
        add(64'h4004, 64'h0123_4567_89AB_CDEF, 2, 1, 0, 0, 4, 64'h0,
            0, 0, 64'h4000, 64'h0123_4567_89AB_CDEF, 8'h00, 64'h0, 0, 1);
        add(64'h1001, 64'hBEEF, 0, 0, 0, 0, 2, 64'h0, 0, 0, 64'h1000, 64'hBEEF_BEEF_BEEF_BEEF, 8'h00, 64'h0, 0, 1);
        add(64'h2002, 64'h0, 12, 1, 1, 5, 0, R2, 0, 0, 64'h2000, 64'h0, 8'h00, 64'h0, 0, 1);
`else
        add(64'h4004, 64'h0, 11, 1, 1, 7, 0, R2, 1, 0, 64'h4000, 64'h0, 8'h00, R2, 1, 0);
        add(64'h4004, 64'h0123_4567_89AB_CDEF, 2, 1, 0, 0, 4, 64'h0,
            1, 1, 64'h4000, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 1, 0);
        add(64'h1001, 64'hBEEF, 0, 0, 0, 0, 2, 64'h0, 1, 1, 64'h1000, 64'hBEEF_BEEF_BEEF_BEEF, 8'h03, 64'h0, 0, 0);
        add(64'h2002, 64'h0, 12, 1, 1, 5, 0, R2, 1, 0, 64'h2000, 64'h0, 8'h00, 64'h0000_0000_5678_9ABC, 1, 0);
`endif

        // Reset state
        reset = 1'b1;
        drive(64'h0, 64'h0, 64'h0, 0, 0, 0, 0, 0, 0, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        chk_wb_zero("rst");
        chk("rst.req", 64'(dmem_req), 64'h0);
        chk("rst.stall", 64'(stall_MEM), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Single-cycle vectors with zero-wait memory
        for (int i = 0; i < vq.size(); i++) begin
            logic [63:0] pc;
            pc = 64'h8000_0000 + 64'(i) * 4;
            @(negedge clk);
            drive(pc, vq[i].alu, vq[i].d2, vq[i].rd, vq[i].wen, vq[i].sel, vq[i].rdc, vq[i].wrc,
                  1'b1, vq[i].rdata);
            #1;
            chk($sformatf("v%0d.req", i), 64'(dmem_req), 64'(vq[i].e_req));
            chk($sformatf("v%0d.we", i), 64'(dmem_we), 64'(vq[i].e_we));
            chk($sformatf("v%0d.addr", i), dmem_addr, vq[i].e_addr);
            chk($sformatf("v%0d.wdata", i), dmem_wdata, vq[i].e_wdata);
            chk($sformatf("v%0d.be", i), 64'(dmem_be), 64'(vq[i].e_be));
            chk($sformatf("v%0d.stall", i), 64'(stall_MEM), 64'h0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.pc_WB", i), pc_WB, pc);
            chk($sformatf("v%0d.alu_WB", i), alu_result_WB, vq[i].alu);
            chk($sformatf("v%0d.mrd_WB", i), mem_rdata_WB, vq[i].e_mrd);
            chk($sformatf("v%0d.rd_WB", i), 64'(rd_WB), 64'(vq[i].rd));
            chk($sformatf("v%0d.wen_WB", i), 64'(rf_wr_en_WB), 64'(vq[i].e_wen));
            chk($sformatf("v%0d.sel_WB", i), 64'(rf_wr_sel_WB), 64'(vq[i].sel));
            chk($sformatf("v%0d.mis", i), 64'(misalign_MEM), 64'(vq[i].e_mis));
        end

        // LW with three wait cycles: stall, stable request, bubbles, then capture
        @(negedge clk);
        drive(64'h9000, 64'h3000, 64'h0, 3, 1, 1, 5, 0, 1'b0, R3);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("w%0d.stall", k), 64'(stall_MEM), 64'h1);
            chk($sformatf("w%0d.req", k), 64'(dmem_req), 64'h1);
            chk($sformatf("w%0d.addr", k), dmem_addr, 64'h3000);
            @(posedge clk);
            #1;
            chk($sformatf("w%0d.wen_WB", k), 64'(rf_wr_en_WB), 64'h0);
            chk($sformatf("w%0d.rd_WB", k), 64'(rd_WB), 64'h0);
            chk($sformatf("w%0d.mis", k), 64'(misalign_MEM), 64'h0);
            @(negedge clk);
        end
        dmem_ready = 1'b1;
        #1;
        chk("wcap.stall", 64'(stall_MEM), 64'h0);
        @(posedge clk);
        #1;
        chk("wcap.mrd_WB", mem_rdata_WB, 64'hFFFF_FFFF_8765_4321);
        chk("wcap.rd_WB", 64'(rd_WB), 64'h3);
        chk("wcap.wen_WB", 64'(rf_wr_en_WB), 64'h1);
        chk("wcap.alu_WB", alu_result_WB, 64'h3000);
        chk("wcap.pc_WB", pc_WB, 64'h9000);

        // Reset while waiting on memory
        @(negedge clk);
        drive(64'h9100, 64'h2008, 64'h0, 6, 1, 1, 7, 0, 1'b0, R2);
        @(posedge clk);
        #1;
        chk("rw.stall", 64'(stall_MEM), 64'h1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_wb_zero("rw");
        @(negedge clk);
        drive(64'h0, 64'h0, 64'h0, 0, 0, 0, 0, 0, 1'b0, 64'h0);
        #1;
        chk("rw.req", 64'(dmem_req), 64'h0);
        chk("rw.stall0", 64'(stall_MEM), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(64'h9200, 64'h55, 64'h0, 1, 1, 0, 0, 0, 1'b0, 64'h0);
        #1;
        chk("post.stall", 64'(stall_MEM), 64'h0);
        @(posedge clk);
        #1;
        chk("post.alu_WB", alu_result_WB, 64'h55);
        chk("post.rd_WB", 64'(rd_WB), 64'h1);
        chk("post.wen_WB", 64'(rf_wr_en_WB), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
